// File: rtl/dm_arbiter.sv
// dm_arbiter: shares the single data-memory port between the CPU MEM stage
// and a debug/loader master. The CPU has default priority. A debug access is
// a registered two-cycle transaction (DBG_ACC then DBG_ACK), and the CPU is
// stalled only while it collides with the DBG_ACC cycle.
//
// Optional feature: define DM_ARB_STARVE_GUARD_EN to build a 4-bit
// starvation counter. With it, a debug request that has been contended for
// STARVE_MAX cycles is forced in at the cost of one CPU stall cycle. Without
// it, debug is granted only in a cycle where the CPU is not requesting.
//
// Handshake: dbg_req is a level request that is held, with stable
// dbg_we/dbg_addr/dbg_wdata, until the one-cycle dbg_ack pulse. The master
// drops dbg_req in the ack cycle; a request still high afterwards is a new
// access. The CPU side has no handshake beyond cpu_stall: while it is high
// the MEM stage holds its request unchanged.
//
// fsm_state exposes the arbiter state (0 IDLE, 1 DBG_ACC, 2 DBG_ACK).
module dm_arbiter #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DBG_ACC = 2'd1,
    DBG_ACK = 2'd2
  } state_t;

  state_t            state;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              starve_hit;
  logic              grant;

  // The counter is only 4 bits wide, so STARVE_MAX must fit in 1..15.
  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
    $error("dm_arbiter: STARVE_MAX must be in 1..15");
  end

  // Debug takes the port from IDLE when the CPU is quiet or has starved it.
  assign grant = (state == IDLE) && dbg_req && (!cpu_req || starve_hit);

`ifdef DM_ARB_STARVE_GUARD_EN
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] cnt;

  assign starve_hit = (cnt == STARVE_LIM);

  // Count contended IDLE cycles; cleared when debug drops or is granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 4'd0;
    end else if (!dbg_req || grant) begin
      cnt <= 4'd0;
    end else if ((state == IDLE) && cpu_req && (cnt != STARVE_LIM)) begin
      cnt <= cnt + 4'd1;
    end
  end
`else
  assign starve_hit = 1'b0;
`endif

  // Arbiter FSM: latch the debug request, run the access, pulse the ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dbg_ack   <= 1'b0;
      dbg_rdata <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          dbg_ack <= 1'b0;
          if (grant) begin
            state     <= DBG_ACC;
            lat_we    <= dbg_we;
            lat_addr  <= dbg_addr;
            lat_wdata <= dbg_wdata;
          end
        end
        DBG_ACC: begin
          // Reads capture DM data; writes leave the last read value in place.
          if (!lat_we) begin
            dbg_rdata <= mem_rdata;
          end
          dbg_ack <= 1'b1;
          state   <= DBG_ACK;
        end
        DBG_ACK: begin
          dbg_ack <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          dbg_ack <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  // DM port mux: CPU owns the port except during DBG_ACC. A CPU request that
  // lands in DBG_ACC is stalled (even in builds without the guard, where the
  // grant rule normally keeps the CPU quiet in that cycle) so it is never lost.
  always_comb begin
    mem_we    = cpu_req & cpu_we;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    cpu_stall = 1'b0;
    if (state == DBG_ACC) begin
      mem_we    = lat_we;
      mem_addr  = lat_addr;
      mem_wdata = lat_wdata;
      cpu_stall = cpu_req;
    end
    // Reset drops any in-flight write, whoever owns the port.
    if (rst) begin
      mem_we = 1'b0;
    end
  end

  assign cpu_rdata = mem_rdata;
  assign fsm_state = state;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed bench for dm_arbiter with a behavioural DM model.
// Inputs are driven away from the rising edge; outputs are sampled at the
// falling edge. Expected read data goes through a scoreboard queue.
module tb_dm_arbiter;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  logic              clk;
  logic              rst;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;
  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_ack;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [1:0]        fsm_state;

  int tests = 0;
  int fails = 0;
  logic [DATA_W-1:0] exp_q[$];

  dm_arbiter #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .STARVE_MAX(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall),
    .dbg_req  (dbg_req),
    .dbg_we   (dbg_we),
    .dbg_addr (dbg_addr),
    .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata),
    .dbg_ack  (dbg_ack),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .fsm_state(fsm_state)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // DM model: combinational read, write on the rising edge.
  logic [DATA_W-1:0] dm [256];
  logic              dm_init;
  logic              pk_en;
  logic [ADDR_W-1:0] pk_addr;
  logic [DATA_W-1:0] pk_data;

  assign mem_rdata = dm[mem_addr];

  always @(posedge clk) begin
    if (dm_init) begin
      for (int i = 0; i < 256; i++) begin
        dm[i] <= (i == 5) ? 16'h1234 : 16'(i * 257);
      end
    end else if (pk_en) begin
      dm[pk_addr] <= pk_data;
    end else if (mem_we) begin
      dm[mem_addr] <= mem_wdata;
    end
  end

  // Driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    cyc();
    #4;
  endtask

  task automatic poke(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    pk_addr = a;
    pk_data = d;
    pk_en   = 1'b1;
    cyc();
    pk_en   = 1'b0;
    #4;
  endtask

  // Scoreboard / checkers
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag, input logic [DATA_W-1:0] obs);
    logic [DATA_W-1:0] exp;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s: observed %h expected <scoreboard empty>", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      check(tag, 32'(obs), 32'(exp));
    end
  endtask

  int acks;
  int stalls;
  int ack_cyc[$];

  initial begin
    dm_init   = 1'b1;
    pk_en     = 1'b0;
    pk_addr   = '0;
    pk_data   = '0;
    rst       = 1'b1;
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 8'h07;
    cpu_wdata = 16'h5555;
    dbg_req   = 1'b1;
    dbg_we    = 1'b1;
    dbg_addr  = 8'h09;
    dbg_wdata = 16'hFFFF;

    // Reset held for two edges with both masters requesting writes.
    cyc();
    dm_init = 1'b0;
    #4;
    for (int k = 0; k < 2; k++) begin
      check("rst_ack", 32'(dbg_ack), 0);
      check("rst_rdata", 32'(dbg_rdata), 0);
      check("rst_stall", 32'(cpu_stall), 0);
      check("rst_mem_we", 32'(mem_we), 0);
      check("rst_state", 32'(fsm_state), 32'(S_IDLE));
      if (k == 0) step();
    end
    check("rst_dm7", 32'(dm[7]), 32'h0707);
    check("rst_dm9", 32'(dm[9]), 32'h0909);
    rst     = 1'b0;
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
    dbg_req = 1'b0;
    step();

    // CPU store then load from the same address.
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 8'h03;
    cpu_wdata = 16'h00AA;
    #1;
    check("cpu_st_mem_we", 32'(mem_we), 1);
    check("cpu_st_stall", 32'(cpu_stall), 0);
    step();
    cpu_we = 1'b0;
    exp_q.push_back(16'h00AA);
    #1;
    sb_check("cpu_ld_rdata", cpu_rdata);
    check("cpu_dm3", 32'(dm[3]), 32'h00AA);
    check("cpu_ld_stall", 32'(cpu_stall), 0);
    cpu_req = 1'b0;

    // Debug read while the CPU is idle.
    dbg_req  = 1'b1;
    dbg_we   = 1'b0;
    dbg_addr = 8'h05;
    exp_q.push_back(16'h1234);
    #1;
    check("rd_pre_ack", 32'(dbg_ack), 0);
    step();
    check("rd_acc_state", 32'(fsm_state), 32'(S_ACC));
    check("rd_acc_ack", 32'(dbg_ack), 0);
    check("rd_acc_stall", 32'(cpu_stall), 0);
    check("rd_acc_addr", 32'(mem_addr), 32'h05);
    check("rd_acc_we", 32'(mem_we), 0);
    step();
    check("rd_ack", 32'(dbg_ack), 1);
    check("rd_ack_state", 32'(fsm_state), 32'(S_ACK));
    sb_check("rd_rdata", dbg_rdata);
    dbg_req = 1'b0;
    step();
    check("rd_post_ack", 32'(dbg_ack), 0);
    check("rd_post_state", 32'(fsm_state), 32'(S_IDLE));
    check("rd_hold_rdata", 32'(dbg_rdata), 32'h1234);

    // Contention: CPU loads continuously while debug writes BEEF to 07.
    cpu_req   = 1'b1;
    cpu_we    = 1'b0;
    cpu_addr  = 8'h03;
    dbg_req   = 1'b1;
    dbg_we    = 1'b1;
    dbg_addr  = 8'h07;
    dbg_wdata = 16'hBEEF;
`ifdef DM_ARB_STARVE_GUARD_EN
    for (int k = 1; k <= 4; k++) begin
      step();
      check("starve_wait_state", 32'(fsm_state), 32'(S_IDLE));
      check("starve_wait_stall", 32'(cpu_stall), 0);
    end
    step();
    check("starve_acc_state", 32'(fsm_state), 32'(S_ACC));
    check("starve_acc_stall", 32'(cpu_stall), 1);
    check("starve_acc_we", 32'(mem_we), 1);
    check("starve_acc_wdata", 32'(mem_wdata), 32'hBEEF);
    step();
    check("starve_ack", 32'(dbg_ack), 1);
    check("starve_ack_stall", 32'(cpu_stall), 0);
    check("starve_dm7", 32'(dm[7]), 32'hBEEF);
    check("starve_hold_rdata", 32'(dbg_rdata), 32'h1234);
    dbg_req = 1'b0;
    cpu_req = 1'b0;
    step();
    check("starve_post_state", 32'(fsm_state), 32'(S_IDLE));
    check("starve_post_ack", 32'(dbg_ack), 0);
`else
    acks   = 0;
    stalls = 0;
    for (int k = 0; k < 50; k++) begin
      step();
      if (dbg_ack) acks++;
      if (cpu_stall) stalls++;
    end
    check("noguard_acks", 32'(acks), 0);
    check("noguard_stalls", 32'(stalls), 0);
    check("noguard_dm7", 32'(dm[7]), 32'h0707);
    cpu_req = 1'b0;
    step();
    check("noguard_acc_state", 32'(fsm_state), 32'(S_ACC));
    check("noguard_acc_we", 32'(mem_we), 1);
    step();
    check("noguard_ack", 32'(dbg_ack), 1);
    check("noguard_dm7_w", 32'(dm[7]), 32'hBEEF);
    check("noguard_hold_rdata", 32'(dbg_rdata), 32'h1234);
    dbg_req = 1'b0;
    step();
    check("noguard_post_ack", 32'(dbg_ack), 0);
`endif

    // Reset during DBG_ACC of a debug write: write and ack are dropped.
    poke(8'h07, 16'h0707);
    cpu_req   = 1'b0;
    dbg_req   = 1'b1;
    dbg_we    = 1'b1;
    dbg_addr  = 8'h07;
    dbg_wdata = 16'hBEEF;
    step();
    check("rmid_acc_state", 32'(fsm_state), 32'(S_ACC));
    check("rmid_acc_we", 32'(mem_we), 1);
    rst     = 1'b1;
    dbg_req = 1'b0;
    #1;
    check("rmid_we_forced", 32'(mem_we), 0);
    step();
    check("rmid_state", 32'(fsm_state), 32'(S_IDLE));
    check("rmid_ack", 32'(dbg_ack), 0);
    check("rmid_dm7", 32'(dm[7]), 32'h0707);
    check("rmid_rdata", 32'(dbg_rdata), 0);
    rst = 1'b0;
    step();

    // Back-to-back debug reads with dbg_req held across the first ack.
    dbg_req  = 1'b1;
    dbg_we   = 1'b0;
    dbg_addr = 8'h05;
    exp_q.push_back(16'h1234);
    exp_q.push_back(16'h00AA);
    for (int i = 0; i < 8; i++) begin
      step();
      if (dbg_ack) begin
        ack_cyc.push_back(i);
        sb_check("b2b_rdata", dbg_rdata);
        if (ack_cyc.size() == 1) dbg_addr = 8'h03;
        else dbg_req = 1'b0;
      end
    end
    dbg_req = 1'b0;
    check("b2b_ack_count", 32'(ack_cyc.size()), 2);
    check("b2b_spacing", (ack_cyc.size() == 2) ? 32'(ack_cyc[1] - ack_cyc[0]) : 32'd0, 3);
    check("sb_drained", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Data-memory access arbiter and sequencer for the 5-stage pipelined CPU. It shares the single data-memory port between the pipeline's MEM stage and a debug/loader port. The CPU has default priority. Debug accesses run as a registered two-cycle transaction, and the CPU is stalled only when it actually collides with one. The block sits between the MEM stage, the DM array and the bench/debug master.

## Interface
Parameters:
- DATA_W, 16, data word width
- ADDR_W, 8, DM word-address width
- STARVE_MAX, 4, contended cycles tolerated before debug is forced in (guard builds only), range 1..15

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- cpu_req  in  1  MEM stage requests DM this cycle
- cpu_we  in  1  MEM stage write enable
- cpu_addr  in  ADDR_W  MEM stage address
- cpu_wdata  in  DATA_W  MEM stage store data
- cpu_rdata  out  DATA_W  load data to MEM stage; equals mem_rdata
- cpu_stall  out  1  freeze PC/IF/ID/EX/MEM and hold the MEM request
- dbg_req  in  1  debug access request; level, held until dbg_ack
- dbg_we  in  1  debug write enable
- dbg_addr  in  ADDR_W  debug address
- dbg_wdata  in  DATA_W  debug write data
- dbg_rdata  out  DATA_W  registered debug read data
- dbg_ack  out  1  one-cycle completion pulse
- mem_we  out  1  DM write enable; DM writes on the clk edge
- mem_addr  out  ADDR_W  DM address
- mem_wdata  out  DATA_W  DM write data
- mem_rdata  in  DATA_W  DM combinational read data

## Operation
- FSM states: IDLE, DBG_ACC, DBG_ACK. Reset state is IDLE.
- IDLE:
  - The DM port is muxed to the CPU: mem_we = cpu_req & cpu_we, mem_addr = cpu_addr, mem_wdata = cpu_wdata.
  - cpu_stall = 0.
  - Move to DBG_ACC when dbg_req & (!cpu_req | starve_hit). On that transition, latch dbg_we, dbg_addr and dbg_wdata.
- DBG_ACC:
  - The DM port is driven from the latched debug fields.
  - cpu_stall = cpu_req.
  - On the edge, dbg_rdata <= mem_rdata, captured only if the latched we = 0; on writes dbg_rdata is held.
  - Always move to DBG_ACK.
- DBG_ACK:
  - dbg_ack = 1. The DM port returns to the CPU, as in IDLE, and cpu_stall = 0.
  - Always move to IDLE. The debug master must deassert dbg_req in this cycle. A request still high in IDLE is treated as a new access.
- Starvation counter, 4 bits, guard builds only:
  - In IDLE it increments on each edge where dbg_req & cpu_req and no transition is taken, saturating at STARVE_MAX.
  - It clears on any edge where dbg_req = 0, and on entering DBG_ACC.
  - starve_hit = (cnt == STARVE_MAX).
- Simultaneous cpu_req and dbg_req in IDLE with starve_hit = 0: the CPU wins, with no stall.
- cpu_rdata = mem_rdata in every state. It is meaningless to the CPU while cpu_stall = 1.
- mem_we is forced to 0 whenever rst = 1, regardless of state, so an in-flight debug or CPU write is dropped.

## Timing
- Reset values: state IDLE, dbg_ack 0, dbg_rdata 0, cnt 0, cpu_stall 0, mem_we 0.
- CPU path: zero added latency. It is combinational to DM, with the write committing at the edge ending the request cycle.
- Debug latency when granted immediately: dbg_req is sampled high at edge N, DBG_ACC occupies cycle N..N+1, and dbg_ack is high during cycle N+1..N+2 with dbg_rdata valid.
- Minimum debug-to-debug spacing is 3 cycles.
- Stall length per forced debug access is exactly 1 cycle.
- Reset mid-transaction (rst high while in DBG_ACC or DBG_ACK): no DM write, no dbg_ack pulse after the edge, and the state returns to IDLE.

## Configuration
- DM_ARB_STARVE_GUARD_EN defined:
  - The starvation counter and STARVE_MAX are present.
  - Debug is forced in after STARVE_MAX contended cycles, at the cost of a 1-cycle CPU stall.
- Undefined:
  - No counter is built and starve_hit is 0.
  - Debug is granted only in a cycle with cpu_req = 0, so cpu_stall is constant 0.
  - STARVE_MAX is ignored.

## Test plan
- Reset: hold rst = 1 for 2 cycles with dbg_req = 1 and cpu_req = 1, cpu_we = 1 -> dbg_ack = 0, dbg_rdata = 0000, cpu_stall = 0, mem_we = 0; DM unchanged.
- CPU store/load: cpu_req = 1, cpu_we = 1, addr 03, data 00AA for 1 cycle, then a load from addr 03 -> DM[3] = 00AA and cpu_rdata = 00AA in the same cycle; cpu_stall stays 0.
- Debug read while CPU idle: DM[5] = 1234; dbg_req with addr 05, we = 0, sampled at edge N -> dbg_ack high only in cycle N+1..N+2 with dbg_rdata = 1234; cpu_stall = 0 throughout.
- Contention with guard on, STARVE_MAX = 4:
  - Stimulus: cpu_req held at 1 and a debug write of BEEF to addr 07 raised together.
  - Required: cnt reaches 4 after 4 edges, DBG_ACC is entered at edge 5, cpu_stall = 1 for exactly one cycle, DM[7] = BEEF, and dbg_ack follows.
  - Guard off: no dbg_ack within 50 cycles; dbg_ack asserts 2 cycles after cpu_req drops.
- Reset mid-op: a debug write of BEEF to addr 07 reaches DBG_ACC, and rst is asserted in that cycle -> DM[7] is unchanged, no dbg_ack pulse, and the state is IDLE after the edge.
- Back-to-back: dbg_req held high across the ack -> a second access starts from IDLE, and the two dbg_ack pulses are exactly 3 cycles apart.
